// File: rtl/ca_pkg.sv
// Shared constants for the cellular-automaton display: sequencer state encoding,
// scan limits and the colour / cell values used by the colour logic.
package ca_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_WAIT_GEN = 2'd2,
        ST_DRAW     = 2'd3
    } ca_state_e;

    localparam logic [8:0] CA_SCREEN_X_MAX = 9'd319;
    localparam logic [7:0] CA_SCREEN_Y_MAX = 8'd239;
    localparam logic [8:0] CA_GRID_X_MAX   = 9'd15;
    localparam logic [7:0] CA_GRID_Y_MAX   = 8'd15;

    localparam logic       CA_CELL_DEAD    = 1'b0;
    localparam logic       CA_CELL_ALIVE   = 1'b1;
    localparam logic [2:0] CA_COLOUR_WHITE = 3'b111;
    localparam logic [2:0] CA_COLOUR_BLACK = 3'b000;

    function automatic logic [2:0] ca_cell_colour(input logic alive);
        logic [2:0] colour;
        if (alive == CA_CELL_ALIVE) begin
            colour = CA_COLOUR_BLACK;
        end else begin
            colour = CA_COLOUR_WHITE;
        end
        return colour;
    endfunction

endpackage

// File: rtl/ca_scan_step.sv
// Row-major scan step decoder: from the current (x,y) and the scan limits decide
// whether to advance x, wrap the row, or finish the frame.
module ca_scan_step #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [XW-1:0] xmax,
    input  logic [YW-1:0] ymax,
    output logic          x_en,
    output logic          x_clr,
    output logic          y_en,
    output logic          last
);

    logic x_end_s;
    logic y_end_s;

    // Decode the step from the position relative to the limits
    always_comb begin
        x_end_s = (x >= xmax);
        y_end_s = (y >= ymax);
        x_en    = ~x_end_s;
        x_clr   = x_end_s;
        y_en    = x_end_s & ~y_end_s;
        last    = x_end_s & y_end_s;
    end

endmodule

// File: rtl/ca_frame_sequencer.sv
// Control FSM for the cellular-automaton display: one full-screen clear after Start,
// then one cell-grid redraw per generation tick. Optional Pause/Step via CA_SEQ_PAUSE_EN.
module ca_frame_sequencer
    import ca_pkg::*;
#(
    parameter logic [8:0] X_CLEAR_MAX = CA_SCREEN_X_MAX,
    parameter logic [7:0] Y_CLEAR_MAX = CA_SCREEN_Y_MAX,
    parameter logic [8:0] X_DRAW_MAX  = CA_GRID_X_MAX,
    parameter logic [7:0] Y_DRAW_MAX  = CA_GRID_Y_MAX
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
`ifdef CA_SEQ_PAUSE_EN
    input  logic       Pause,
    input  logic       Step,
`endif
    input  logic       GenTick,
    input  logic [8:0] xClear,
    input  logic [7:0] yClear,
    input  logic [8:0] xCountDraw,
    input  logic [7:0] yCountDraw,
    output logic       CXC_Resetn,
    output logic       CYC_Resetn,
    output logic       CXD_Resetn,
    output logic       CYD_Resetn,
    output logic       CXC_Enable,
    output logic       CYC_Enable,
    output logic       CXD_Enable,
    output logic       CYD_Enable,
    output logic       isDraw,
    output logic       Plot,
    output logic       Busy,
    output logic       FrameDone
);

    ca_state_e state_q, state_d;
    logic      pending_q, pending_d;
    logic      go_draw_s;

    logic c_x_en_s, c_x_clr_s, c_y_en_s, c_last_s;
    logic d_x_en_s, d_x_clr_s, d_y_en_s, d_last_s;

    ca_scan_step #(.XW(9), .YW(8)) u_clear_step (
        .x     (xClear),
        .y     (yClear),
        .xmax  (X_CLEAR_MAX),
        .ymax  (Y_CLEAR_MAX),
        .x_en  (c_x_en_s),
        .x_clr (c_x_clr_s),
        .y_en  (c_y_en_s),
        .last  (c_last_s)
    );

    ca_scan_step #(.XW(9), .YW(8)) u_draw_step (
        .x     (xCountDraw),
        .y     (yCountDraw),
        .xmax  (X_DRAW_MAX),
        .ymax  (Y_DRAW_MAX),
        .x_en  (d_x_en_s),
        .x_clr (d_x_clr_s),
        .y_en  (d_y_en_s),
        .last  (d_last_s)
    );

    // Decide whether WAIT_GEN launches a redraw this cycle
    always_comb begin
`ifdef CA_SEQ_PAUSE_EN
        if (Pause) begin
            go_draw_s = Step;
        end else begin
            go_draw_s = GenTick | pending_q;
        end
`else
        go_draw_s = GenTick | pending_q;
`endif
    end

    // Next state and one-deep generation-tick memory
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (GenTick) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (c_last_s) begin
                    state_d = ST_WAIT_GEN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_WAIT_GEN: begin
                if (go_draw_s) begin
                    state_d   = ST_DRAW;
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_WAIT_GEN;
                end
            end
            ST_DRAW: begin
                if (GenTick) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (d_last_s) begin
                    state_d = ST_WAIT_GEN;
                end else begin
                    state_d = ST_DRAW;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Mealy outputs; counters not owned by the active scan are held cleared
    always_comb begin
        CXC_Resetn = 1'b0;
        CYC_Resetn = 1'b0;
        CXD_Resetn = 1'b0;
        CYD_Resetn = 1'b0;
        CXC_Enable = 1'b0;
        CYC_Enable = 1'b0;
        CXD_Enable = 1'b0;
        CYD_Enable = 1'b0;
        isDraw     = 1'b0;
        Plot       = 1'b0;
        Busy       = 1'b0;
        FrameDone  = 1'b0;
        if (!Resetn) begin
            Plot = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    Plot = 1'b0;
                end
                ST_CLEAR: begin
                    Plot       = 1'b1;
                    Busy       = 1'b1;
                    CXC_Resetn = ~c_x_clr_s;
                    CYC_Resetn = ~c_last_s;
                    CXC_Enable = c_x_en_s;
                    CYC_Enable = c_y_en_s;
                    FrameDone  = c_last_s;
                end
                ST_WAIT_GEN: begin
                    isDraw = 1'b1;
                end
                ST_DRAW: begin
                    isDraw     = 1'b1;
                    Plot       = 1'b1;
                    Busy       = 1'b1;
                    CXD_Resetn = ~d_x_clr_s;
                    CYD_Resetn = ~d_last_s;
                    CXD_Enable = d_x_en_s;
                    CYD_Enable = d_y_en_s;
                    FrameDone  = d_last_s;
                end
                default: begin
                    Plot = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ca_frame_sequencer.sv
// Scoreboard bench for ca_frame_sequencer with small scan limits; models the four
// external counters and predicts frames from the sequencing rules.
module tb_ca_frame_sequencer;

    localparam int CW = 4;
    localparam int CH = 3;
    localparam int DW = 2;
    localparam int DH = 2;
    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_WAIT  = 2;
    localparam int M_DRAW  = 3;
`ifdef CA_SEQ_PAUSE_EN
    localparam bit PAUSE_BUILT = 1'b1;
`else
    localparam bit PAUSE_BUILT = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Resetn, Start, GenTick, Pause, Step;
    logic [8:0] cx, dx;
    logic [7:0] cy, dy;
    logic CXC_Resetn, CYC_Resetn, CXD_Resetn, CYD_Resetn;
    logic CXC_Enable, CYC_Enable, CXD_Enable, CYD_Enable;
    logic isDraw, Plot, Busy, FrameDone;

    typedef struct {
        int x;
        int y;
        bit draw;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    int   m_mode = M_IDLE;
    int   m_left = 0;
    bit   m_pend = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 Clock = ~Clock;

    ca_frame_sequencer #(
        .X_CLEAR_MAX(9'd3),
        .Y_CLEAR_MAX(8'd2),
        .X_DRAW_MAX (9'd1),
        .Y_DRAW_MAX (8'd1)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
`ifdef CA_SEQ_PAUSE_EN
        .Pause      (Pause),
        .Step       (Step),
`endif
        .GenTick    (GenTick),
        .xClear     (cx),
        .yClear     (cy),
        .xCountDraw (dx),
        .yCountDraw (dy),
        .CXC_Resetn (CXC_Resetn),
        .CYC_Resetn (CYC_Resetn),
        .CXD_Resetn (CXD_Resetn),
        .CYD_Resetn (CYD_Resetn),
        .CXC_Enable (CXC_Enable),
        .CYC_Enable (CYC_Enable),
        .CXD_Enable (CXD_Enable),
        .CYD_Enable (CYD_Enable),
        .isDraw     (isDraw),
        .Plot       (Plot),
        .Busy       (Busy),
        .FrameDone  (FrameDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input int w, input int h, input bit draw);
        pix_t p;
        for (int i = 0; i < w * h; i++) begin
            p.x    = i % w;
            p.y    = i / w;
            p.draw = draw;
            p.last = (i == w * h - 1);
            exp_q.push_back(p);
        end
    endfunction

    // Datapath counters driven by the sequencer outputs
    always @(posedge Clock) begin
        if (!CXC_Resetn) cx <= 9'd0; else if (CXC_Enable) cx <= cx + 9'd1;
        if (!CYC_Resetn) cy <= 8'd0; else if (CYC_Enable) cy <= cy + 8'd1;
        if (!CXD_Resetn) dx <= 9'd0; else if (CXD_Enable) dx <= dx + 9'd1;
        if (!CYD_Resetn) dy <= 8'd0; else if (CYD_Enable) dy <= dy + 8'd1;
    end

    // Reference model: frame-level sequencing, pushing every expected pixel
    always @(posedge Clock) begin
        if (!Resetn) begin
            m_mode <= M_IDLE;
            m_pend <= 1'b0;
            m_left <= 0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (Start) begin
                        m_mode <= M_CLEAR;
                        m_left <= CW * CH;
                        push_frame(CW, CH, 1'b0);
                    end
                end
                M_CLEAR, M_DRAW: begin
                    if (GenTick) m_pend <= 1'b1;
                    if (m_left == 1) m_mode <= M_WAIT;
                    m_left <= m_left - 1;
                end
                M_WAIT: begin
                    if ((PAUSE_BUILT && Pause) ? Step : (GenTick || m_pend)) begin
                        m_mode <= M_DRAW;
                        m_pend <= 1'b0;
                        m_left <= DW * DH;
                        push_frame(DW, DH, 1'b1);
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge
    always @(negedge Clock) begin
        pix_t e;
        bit   busy_exp;
        if (!Resetn) begin
            check("rst_plot", {31'd0, Plot}, 32'd0);
            check("rst_outs", {20'd0, CXC_Resetn, CYC_Resetn, CXD_Resetn, CYD_Resetn,
                               CXC_Enable, CYC_Enable, CXD_Enable, CYD_Enable,
                               isDraw, Plot, Busy, FrameDone}, 32'd0);
        end else begin
            busy_exp = (m_mode == M_CLEAR) || (m_mode == M_DRAW);
            check("busy", {31'd0, Busy}, {31'd0, busy_exp});
            check("plot", {31'd0, Plot}, {31'd0, busy_exp});
            check("en_excl", {31'd0, (CXC_Enable | CYC_Enable) & (CXD_Enable | CYD_Enable)}, 32'd0);
            if (Plot) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_unexpected actual=plot expected=no_plot t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("isdraw", {31'd0, isDraw}, {31'd0, e.draw});
                    check("pix_x", isDraw ? 32'(dx) : 32'(cx), e.x);
                    check("pix_y", isDraw ? 32'(dy) : 32'(cy), e.y);
                    check("framedone", {31'd0, FrameDone}, {31'd0, e.last});
                end
            end else begin
                check("idle_framedone", {31'd0, FrameDone}, 32'd0);
                check("idle_counters", 32'(cx) + 32'(cy) + 32'(dx) + 32'(dy), 32'd0);
                if (m_mode == M_WAIT) check("wait_isdraw", {31'd0, isDraw}, 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0; Start = 1'b0; GenTick = 1'b0; Pause = 1'b0; Step = 1'b0;
        repeat (3) cyc();
        Resetn = 1'b1;
        repeat (2) cyc();
        // clear, then one tick-driven draw with a second tick in draw cycle 2
        Start = 1'b1; cyc(); Start = 1'b0;
        repeat (14) cyc();
        GenTick = 1'b1; cyc(); GenTick = 1'b0; cyc();
        GenTick = 1'b1; cyc(); GenTick = 1'b0;
        repeat (12) cyc();
        // three ticks inside one draw yield a single extra draw
        GenTick = 1'b1; cyc();
        repeat (3) cyc();
        GenTick = 1'b0;
        repeat (15) cyc();
        // reset mid-clear, tick in idle is ignored, Start restarts
        Start = 1'b1; cyc(); Start = 1'b0;
        repeat (4) cyc();
        Resetn = 1'b0; cyc(); Resetn = 1'b1;
        repeat (4) cyc();
        GenTick = 1'b1; cyc(); GenTick = 1'b0;
        repeat (3) cyc();
        Start = 1'b1; cyc(); Start = 1'b0;
        repeat (14) cyc();
`ifdef CA_SEQ_PAUSE_EN
        Pause = 1'b1;
        GenTick = 1'b1; cyc(); GenTick = 1'b0;
        repeat (5) cyc();
        Step = 1'b1; cyc(); Step = 1'b0;
        repeat (8) cyc();
        Pause = 1'b0;
        repeat (4) cyc();
`endif
        for (int i = 0; i < 1500; i++) begin
            Start   = ($urandom_range(0, 31) == 0);
            GenTick = ($urandom_range(0, 5) == 0);
            Resetn  = ($urandom_range(0, 199) != 0);
`ifdef CA_SEQ_PAUSE_EN
            Pause   = ($urandom_range(0, 3) == 0);
            Step    = ($urandom_range(0, 9) == 0);
`endif
            cyc();
        end
        Start = 1'b0; GenTick = 1'b0; Resetn = 1'b1; Pause = 1'b0; Step = 1'b0;
        repeat (40) cyc();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
